// File: rtl/layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer_pkg
//  Purpose  : Shared constants, types and state encoding for the spiking-layer
//             gamma-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package layer_sequencer_pkg;

    localparam int TIME_PERIOD     = 8;
    localparam int LOG_TIME_PERIOD = 3;
    localparam int NUM_SPIKES      = 16;
    localparam int LOG_NEURONS     = 4;

    localparam int TIME_W   = LOG_TIME_PERIOD + 1;
    localparam int NEURON_W = LOG_NEURONS + 1;
    localparam int VOLLEY_W = NUM_SPIKES * TIME_W;

    typedef logic [TIME_W-1:0]   time_t;
    typedef logic [NEURON_W-1:0] neuron_t;
    typedef logic [VOLLEY_W-1:0] volley_t;

    // All-ones encodings: MSB set on a time value means "no spike".
    localparam time_t   NO_SPIKE   = '1;
    localparam neuron_t NO_WINNER  = '1;
    localparam volley_t NO_VOLLEY  = '1;
    localparam time_t   LAST_STEP  = time_t'(TIME_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        ABORT  = 2'd2,
        RESULT = 2'd3
    } seq_state_e;

    // A time value carries a spike when its MSB is clear.
    function automatic logic is_spike(input time_t t);
        return ~t[TIME_W-1];
    endfunction

endpackage : layer_sequencer_pkg
`default_nettype wire

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer_if
//  Purpose  : Bundles the volley handshake, result handshake and layer bus of
//             the sequencer. slave = sequencer side, master = environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if;
    import layer_sequencer_pkg::*;

    // Volley input handshake
    logic    in_valid;
    logic    in_ready;
    volley_t in_spike_times;
    logic    in_train;
    logic    abort;

    // Layer bus
    time_t   lyr_time_val;
    volley_t lyr_spike_times;
    logic    lyr_training;
    time_t   lyr_out_time;
    neuron_t lyr_winner;

    // Result handshake
    logic    res_valid;
    logic    res_ready;
    time_t   res_spike_time;
    neuron_t res_neuron;

    modport slave (
        input  in_valid, in_spike_times, in_train, abort,
        input  lyr_out_time, lyr_winner, res_ready,
        output in_ready, lyr_time_val, lyr_spike_times, lyr_training,
        output res_valid, res_spike_time, res_neuron
    );

    modport master (
        output in_valid, in_spike_times, in_train, abort,
        output lyr_out_time, lyr_winner, res_ready,
        input  in_ready, lyr_time_val, lyr_spike_times, lyr_training,
        input  res_valid, res_spike_time, res_neuron
    );

endinterface : layer_sequencer_if
`default_nettype wire

// File: rtl/layer_sequencer_stat_counters.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stat_counters
//  Purpose  : Statistics pair - one wrapping event counter and one saturating
//             event counter, each with its own increment enable.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_stat_counters #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_inc_wrap,
    input  wire logic         i_inc_sat,
    output logic [W-1:0]      o_cnt_wrap,
    output logic [W-1:0]      o_cnt_sat
);

    logic [W-1:0] cnt_wrap_q, cnt_wrap_d;
    logic [W-1:0] cnt_sat_q,  cnt_sat_d;

    // Next-count logic: wrap counter rolls over, saturating counter sticks at all-ones.
    always_comb begin
        cnt_wrap_d = cnt_wrap_q;
        cnt_sat_d  = cnt_sat_q;
        if (i_inc_wrap) begin
            cnt_wrap_d = cnt_wrap_q + W'(1);
        end
        if (i_inc_sat && (cnt_sat_q != '1)) begin
            cnt_sat_d = cnt_sat_q + W'(1);
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_wrap_q <= '0;
            cnt_sat_q  <= '0;
        end else begin
            cnt_wrap_q <= cnt_wrap_d;
            cnt_sat_q  <= cnt_sat_d;
        end
    end

    assign o_cnt_wrap = cnt_wrap_q;
    assign o_cnt_sat  = cnt_sat_q;

endmodule : seq_stat_counters
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer
//  Purpose  : Sequences one spiking layer through gamma cycles: accepts a
//             volley, steps time_val 0..TIME_PERIOD-1, captures the first
//             output spike and winner, and returns it as a result.
//  Options  : LAYER_SEQUENCER_EARLY_EXIT_EN - inference volleys flush and
//             finish on the step after the first captured spike.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    layer_sequencer_if.slave    bus,
    output logic [STAT_W-1:0]   stat_volleys,
    output logic [STAT_W-1:0]   stat_silent
);

    seq_state_e state_q,     state_d;
    time_t      time_val_q,  time_val_d;
    volley_t    spikes_q,    spikes_d;
    // Holds in_train of the current volley during RUN, zero in every other state.
    logic       training_q,  training_d;
    logic       captured_q,  captured_d;
    time_t      res_time_q,  res_time_d;
    neuron_t    res_neuron_q, res_neuron_d;
    logic       res_valid_q, res_valid_d;

    logic       capture_now;
    logic       stat_volley_inc;
    logic       stat_silent_inc;

    // Next-state, layer drive, capture and statistics-enable decode.
    always_comb begin
        state_d         = state_q;
        time_val_d      = time_val_q;
        spikes_d        = spikes_q;
        training_d      = training_q;
        captured_d      = captured_q;
        res_time_d      = res_time_q;
        res_neuron_d    = res_neuron_q;
        res_valid_d     = res_valid_q;
        capture_now     = 1'b0;
        stat_volley_inc = 1'b0;
        stat_silent_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d      = RUN;
                    time_val_d   = '0;
                    spikes_d     = bus.in_spike_times;
                    training_d   = bus.in_train;
                    captured_d   = 1'b0;
                    res_time_d   = NO_SPIKE;
                    res_neuron_d = NO_WINNER;
                end
            end

            RUN: begin
                // The layer output lags time_val by one cycle, so the
                // time_val=0 sample belongs to the previous volley.
                capture_now = (time_val_q != '0) && !captured_q
                              && is_spike(bus.lyr_out_time);
                if (capture_now) begin
                    captured_d   = 1'b1;
                    res_time_d   = bus.lyr_out_time;
                    res_neuron_d = bus.lyr_winner;
                end

                if (bus.abort) begin
                    // Last step with training low clears the layer without STDP.
                    state_d    = ABORT;
                    time_val_d = LAST_STEP;
                    training_d = 1'b0;
                    spikes_d   = NO_VOLLEY;
                end else if (time_val_q == LAST_STEP) begin
                    state_d         = RESULT;
                    time_val_d      = '0;
                    training_d      = 1'b0;
                    spikes_d        = NO_VOLLEY;
                    res_valid_d     = 1'b1;
                    stat_volley_inc = 1'b1;
                    stat_silent_inc = !captured_d;
                end else begin
                    time_val_d = time_val_q + time_t'(1);
`ifdef LAYER_SEQUENCER_EARLY_EXIT_EN
                    // Inference only: jump to the flush step once a winner is known.
                    if (capture_now && !training_q) begin
                        time_val_d = LAST_STEP;
                    end
`endif
                end
            end

            ABORT: begin
                state_d    = IDLE;
                time_val_d = '0;
                training_d = 1'b0;
                spikes_d   = NO_VOLLEY;
            end

            RESULT: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                time_val_d  = '0;
                training_d  = 1'b0;
                spikes_d    = NO_VOLLEY;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            time_val_q   <= '0;
            spikes_q     <= NO_VOLLEY;
            training_q   <= 1'b0;
            captured_q   <= 1'b0;
            res_time_q   <= NO_SPIKE;
            res_neuron_q <= NO_WINNER;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_val_q   <= time_val_d;
            spikes_q     <= spikes_d;
            training_q   <= training_d;
            captured_q   <= captured_d;
            res_time_q   <= res_time_d;
            res_neuron_q <= res_neuron_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign bus.in_ready        = (state_q == IDLE);
    assign bus.lyr_time_val    = time_val_q;
    assign bus.lyr_spike_times = spikes_q;
    assign bus.lyr_training    = training_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_spike_time  = res_time_q;
    assign bus.res_neuron      = res_neuron_q;

    seq_stat_counters #(
        .W (STAT_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .i_inc_wrap (stat_volley_inc),
        .i_inc_sat  (stat_silent_inc),
        .o_cnt_wrap (stat_volleys),
        .o_cnt_sat  (stat_silent)
    );

endmodule : layer_sequencer
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_sequencer
//  Purpose  : Directed self-checking bench for layer_sequencer with a small
//             behavioural layer model that emits one spike per volley.
//  Options  : LAYER_SEQUENCER_EARLY_EXIT_EN selects early-exit expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] stat_volleys;
    logic [15:0] stat_silent;

    int n_assert = 0;
    int n_fail   = 0;

    // Layer model configuration: fire at step spike_step (-1 = never).
    int          spike_step   = -1;
    logic [4:0]  spike_neuron = '0;

    localparam volley_t V1 = 64'h0123_4567_89AB_0123;
    localparam volley_t V3 = 64'h7654_3210_7654_3210;
    localparam volley_t V5 = 64'h0000_1111_2222_3333;

`ifdef LAYER_SEQUENCER_EARLY_EXIT_EN
    localparam int EXP_LAT1 = 5;   // spike seen at time_val 3 -> flush -> result
`else
    localparam int EXP_LAT1 = 8;
`endif

    layer_sequencer_if bus ();

    layer_sequencer #(
        .STAT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .stat_volleys (stat_volleys),
        .stat_silent  (stat_silent)
    );

    always #5 clk = ~clk;

    // Layer model: output is registered one step late, held until the
    // TIME_PERIOD-1 step clears it; fires only while a volley runs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.lyr_out_time <= NO_SPIKE;
            bus.lyr_winner   <= NO_WINNER;
        end else if (bus.lyr_time_val == LAST_STEP) begin
            bus.lyr_out_time <= NO_SPIKE;
            bus.lyr_winner   <= NO_WINNER;
        end else if (!bus.in_ready && !bus.res_valid && bus.lyr_out_time[TIME_W-1]
                     && (int'(bus.lyr_time_val) == spike_step)) begin
            bus.lyr_out_time <= time_t'(spike_step);
            bus.lyr_winner   <= spike_neuron;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one volley from IDLE and wait (bounded) for res_valid.
    task automatic run_volley(input volley_t v, input logic trn, input int exp_edges,
                              output int trn_cycles);
        int n;
        bus.in_valid       = 1'b1;
        bus.in_spike_times = v;
        bus.in_train       = trn;
        tick();
        bus.in_valid = 1'b0;
        chk("accept_in_ready", 64'(bus.in_ready), 64'd0);
        chk("accept_time_val", 64'(bus.lyr_time_val), 64'd0);
        chk("accept_spikes", 64'(bus.lyr_spike_times), 64'(v));
        trn_cycles = bus.lyr_training ? 1 : 0;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            tick();
            n++;
            if (bus.lyr_training) trn_cycles++;
        end
        chk("latency", 64'(n), 64'(exp_edges));
        chk("res_valid_up", 64'(bus.res_valid), 64'd1);
    endtask

    task automatic release_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("release_res_valid", 64'(bus.res_valid), 64'd0);
    endtask

    initial begin
        int tc;
        bus.in_valid       = 1'b0;
        bus.in_spike_times = NO_VOLLEY;
        bus.in_train       = 1'b0;
        bus.abort          = 1'b0;
        bus.res_ready      = 1'b0;

        // Reset values, checked before any clock edge (asynchronous reset).
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_time_val", 64'(bus.lyr_time_val), 64'd0);
        chk("rst_training", 64'(bus.lyr_training), 64'd0);
        chk("rst_spikes", 64'(bus.lyr_spike_times), {64{1'b1}});
        chk("rst_res_time", 64'(bus.res_spike_time), 64'hF);
        chk("rst_res_neuron", 64'(bus.res_neuron), 64'h1F);
        chk("rst_stat_volleys", 64'(stat_volleys), 64'd0);
        chk("rst_stat_silent", 64'(stat_silent), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: inference volley, neuron 3 spikes at step 2.
        spike_step = 2; spike_neuron = 5'd3;
        run_volley(V1, 1'b0, EXP_LAT1, tc);
        chk("t1_res_time", 64'(bus.res_spike_time), 64'd2);
        chk("t1_res_neuron", 64'(bus.res_neuron), 64'd3);
        chk("t1_stat_volleys", 64'(stat_volleys), 64'd1);
        chk("t1_stat_silent", 64'(stat_silent), 64'd0);
        chk("t1_time_val", 64'(bus.lyr_time_val), 64'd0);
        chk("t1_spikes", 64'(bus.lyr_spike_times), {64{1'b1}});
        chk("t1_training", 64'(tc), 64'd0);

        // 1b: result held with res_ready low while a new volley is offered.
        bus.in_valid = 1'b1;
        bus.in_spike_times = V3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_res_time", 64'(bus.res_spike_time), 64'd2);
            chk("hold_res_neuron", 64'(bus.res_neuron), 64'd3);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("t1_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t1_release_res_valid", 64'(bus.res_valid), 64'd0);
        tick();
        chk("t1_still_idle", 64'(bus.in_ready), 64'd1);

        // 2: silent volley.
        spike_step = -1;
        run_volley(NO_VOLLEY, 1'b0, 8, tc);
        chk("t2_training_cycles", 64'(tc), 64'd0);
        chk("t2_res_time", 64'(bus.res_spike_time), 64'hF);
        chk("t2_res_neuron", 64'(bus.res_neuron), 64'h1F);
        chk("t2_stat_volleys", 64'(stat_volleys), 64'd2);
        chk("t2_stat_silent", 64'(stat_silent), 64'd1);
        release_result();

        // 3: training volley always runs the full period.
        spike_step = 2; spike_neuron = 5'd5;
        run_volley(V3, 1'b1, 8, tc);
        chk("t3_training_cycles", 64'(tc), 64'd8);
        chk("t3_training_after", 64'(bus.lyr_training), 64'd0);
        chk("t3_res_time", 64'(bus.res_spike_time), 64'd2);
        chk("t3_res_neuron", 64'(bus.res_neuron), 64'd5);
        chk("t3_stat_volleys", 64'(stat_volleys), 64'd3);
        release_result();

        // 4: abort at time_val 4 on a training volley.
        spike_step = -1;
        bus.in_valid = 1'b1; bus.in_spike_times = V1; bus.in_train = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_time_val_pre", 64'(bus.lyr_time_val), 64'd4);
        chk("t4_training_pre", 64'(bus.lyr_training), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_abort_time_val", 64'(bus.lyr_time_val), 64'd7);
        chk("t4_abort_training", 64'(bus.lyr_training), 64'd0);
        chk("t4_abort_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t4_abort_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("t4_idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t4_idle_time_val", 64'(bus.lyr_time_val), 64'd0);
        chk("t4_idle_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t4_stat_volleys", 64'(stat_volleys), 64'd3);
        chk("t4_stat_silent", 64'(stat_silent), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_idle_abort_ready", 64'(bus.in_ready), 64'd1);
        chk("t4_idle_abort_tv", 64'(bus.lyr_time_val), 64'd0);
        bus.in_train = 1'b0;

        // 5: capture at time_val 1 (neuron 7 spikes at step 0).
        spike_step = 0; spike_neuron = 5'd7;
`ifdef LAYER_SEQUENCER_EARLY_EXIT_EN
        bus.in_valid = 1'b1; bus.in_spike_times = V5; bus.in_train = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_tv0", 64'(bus.lyr_time_val), 64'd0);
        tick();
        chk("t5_tv1", 64'(bus.lyr_time_val), 64'd1);
        tick();
        chk("t5_tv_flush", 64'(bus.lyr_time_val), 64'd7);
        chk("t5_flush_res_valid", 64'(bus.res_valid), 64'd0);
        tick();
        chk("t5_res_valid", 64'(bus.res_valid), 64'd1);
`else
        run_volley(V5, 1'b0, 8, tc);
`endif
        chk("t5_res_time", 64'(bus.res_spike_time), 64'd0);
        chk("t5_res_neuron", 64'(bus.res_neuron), 64'd7);
        chk("t5_stat_volleys", 64'(stat_volleys), 64'd4);
        chk("t5_stat_silent", 64'(stat_silent), 64'd1);
        release_result();

        // 6: abort coinciding with the final RUN step wins.
        spike_step = -1;
        bus.in_valid = 1'b1; bus.in_spike_times = NO_VOLLEY; bus.in_train = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t6_tv_last", 64'(bus.lyr_time_val), 64'd7);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t6_abort_tv", 64'(bus.lyr_time_val), 64'd7);
        chk("t6_abort_res_valid", 64'(bus.res_valid), 64'd0);
        tick();
        chk("t6_idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t6_idle_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t6_stat_volleys", 64'(stat_volleys), 64'd4);
        chk("t6_stat_silent", 64'(stat_silent), 64'd1);

        // 7: asynchronous reset in the middle of a training volley.
        bus.in_valid = 1'b1; bus.in_spike_times = V1; bus.in_train = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("t7_tv_pre", 64'(bus.lyr_time_val), 64'd2);
        chk("t7_training_pre", 64'(bus.lyr_training), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t7_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t7_time_val", 64'(bus.lyr_time_val), 64'd0);
        chk("t7_training", 64'(bus.lyr_training), 64'd0);
        chk("t7_spikes", 64'(bus.lyr_spike_times), {64{1'b1}});
        chk("t7_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t7_res_time", 64'(bus.res_spike_time), 64'hF);
        chk("t7_res_neuron", 64'(bus.res_neuron), 64'h1F);
        chk("t7_stat_volleys", 64'(stat_volleys), 64'd0);
        chk("t7_stat_silent", 64'(stat_silent), 64'd0);
        tick();
        rst = 1'b0;
        bus.in_train = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_layer_sequencer
`default_nettype wire
